// File: rtl/sm4_pkg.sv
// Shared SM4 constants for the key schedule: FK words, FSM encodings, sizes.
// The DRAIN encoding is only reached when KEYEXP_DEC_EN is defined.
package sm4_pkg;

    localparam int WORD_W = 32;
    localparam int KEY_W  = 128;
    localparam int ROUNDS = 32;

    localparam logic [31:0] FK0 = 32'ha3b1bac6;
    localparam logic [31:0] FK1 = 32'h56aa3350;
    localparam logic [31:0] FK2 = 32'h677d9197;
    localparam logic [31:0] FK3 = 32'hb27022dc;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // CK byte j of round i is (28*i + 7*j) mod 256
    function automatic logic [31:0] gen_ck(input logic [4:0] i);
        logic [7:0] base;
        base = {3'b000, i} * 8'd28;
        gen_ck = {base, base + 8'd7, base + 8'd14, base + 8'd21};
    endfunction

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        l_prime = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sbox_32b.sv
// Four parallel SM4 byte S-boxes applied to a 32-bit word (the tau transform).
module sbox_32b (
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign out_word = {SBOX[in_word[31:24]], SBOX[in_word[23:16]],
                       SBOX[in_word[15:8]],  SBOX[in_word[7:0]]};

endmodule

// File: rtl/keyexp.sv
// SM4 key expansion: one round key per handshake on a valid/ready stream.
// Define KEYEXP_DEC_EN to add DEC_i, a 32-entry buffer and reversed emission.
module keyexp
    import sm4_pkg::*;
(
    input  logic              CLK_i,
    input  logic              RST_N_i,
    input  logic [KEY_W-1:0]  MK_i,
    input  logic              KEY_VALID_i,
    output logic              KEY_READY_o,
`ifdef KEYEXP_DEC_EN
    input  logic              DEC_i,
`endif
    output logic [WORD_W-1:0] RK_o,
    output logic [4:0]        RK_IDX_o,
    output logic              RK_VALID_o,
    input  logic              RK_READY_i,
    output logic              DONE_o
);

    logic [1:0]  state;
    logic [31:0] k0, k1, k2, k3;
    logic [4:0]  idx;
    logic [31:0] ck;
    logic [31:0] tau_in;
    logic [31:0] tau_out;
    logic [31:0] rk_next;
    logic        last;
    logic        advance;
    logic        enc_valid;

`ifdef KEYEXP_DEC_EN
    logic        dec;
    logic [31:0] buffer [ROUNDS];
`endif

    sbox_32b u_sbox (
        .in_word  (tau_in),
        .out_word (tau_out)
    );

    always_comb begin
        ck      = gen_ck(idx);
        tau_in  = k1 ^ k2 ^ k3 ^ ck;
        rk_next = k0 ^ l_prime(tau_out);
        last    = (idx == 5'd31);
`ifdef KEYEXP_DEC_EN
        enc_valid = (state == ST_EXPAND) && !dec;
        // Decrypt expansion runs free into the buffer; only DRAIN waits on the consumer
        advance   = (state == ST_EXPAND) && (dec || RK_READY_i);
`else
        enc_valid = (state == ST_EXPAND);
        advance   = (state == ST_EXPAND) && RK_READY_i;
`endif
    end

    always_comb begin
        KEY_READY_o = (state == ST_IDLE);
        RK_VALID_o  = enc_valid;
        RK_o        = enc_valid ? rk_next : 32'd0;
`ifdef KEYEXP_DEC_EN
        if (state == ST_DRAIN) begin
            RK_VALID_o = 1'b1;
            RK_o       = buffer[~idx];
        end
`endif
        RK_IDX_o = RK_VALID_o ? idx : 5'd0;
        DONE_o   = RK_VALID_o && RK_READY_i && last;
    end

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state <= ST_IDLE;
            k0    <= 32'd0;
            k1    <= 32'd0;
            k2    <= 32'd0;
            k3    <= 32'd0;
            idx   <= 5'd0;
`ifdef KEYEXP_DEC_EN
            dec   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (KEY_VALID_i) begin
                        k0    <= MK_i[127:96] ^ FK0;
                        k1    <= MK_i[95:64]  ^ FK1;
                        k2    <= MK_i[63:32]  ^ FK2;
                        k3    <= MK_i[31:0]   ^ FK3;
                        idx   <= 5'd0;
                        state <= ST_EXPAND;
`ifdef KEYEXP_DEC_EN
                        dec   <= DEC_i;
`endif
                    end
                end
                ST_EXPAND: begin
                    if (advance) begin
                        k0  <= k1;
                        k1  <= k2;
                        k2  <= k3;
                        k3  <= rk_next;
                        idx <= idx + 5'd1;
                        if (last) begin
`ifdef KEYEXP_DEC_EN
                            state <= dec ? ST_DRAIN : ST_IDLE;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef KEYEXP_DEC_EN
                ST_DRAIN: begin
                    if (RK_READY_i) begin
                        idx <= idx + 5'd1;
                        if (last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef KEYEXP_DEC_EN
    always_ff @(posedge CLK_i) begin
        if ((state == ST_EXPAND) && dec) begin
            buffer[idx] <= rk_next;
        end
    end
`endif

endmodule
